rx_buffer_ctrl: RTL and testbench

RX_BUFFER_CTRL -- requirements
Module: rx_buffer_ctrl

---
 rtl/rx_buf_pkg.sv | 32 +++
 rtl/rx_word_assembler.sv | 32 +++
 rtl/rx_buffer_ctrl.sv | 145 ++++++++++++++
 tb/tb_rx_buffer_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_buf_pkg.sv
// Shared types and constants for the RX buffer read/flush controller.
package rx_buf_pkg;

   localparam int unsigned BUF_DEPTH = 64;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRead  = 2'd1,
      StDone  = 2'd2,
      StFlush = 2'd3
   } rx_state_e;

   typedef enum logic [1:0] {
      SzByte = 2'd0,
      SzHalf = 2'd1,
      SzWord = 2'd2,
      SzRsvd = 2'd3
   } rd_size_e;

   // Bytes moved by a read of the given size; 0 marks the reserved encoding.
   function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
      logic [2:0] n;
      case (rd_size_e'(size))
         SzByte:  n = 3'd1;
         SzHalf:  n = 3'd2;
         SzWord:  n = 3'd4;
         default: n = 3'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/rx_word_assembler.sv
// Packs buffer bytes little-endian into a 32-bit read word and tracks the byte lane.
module rx_word_assembler (
   input  logic        i_clk,
   input  logic        i_n_rst,
   input  logic        i_clear,
   input  logic        i_capture,
   input  logic [7:0]  i_byte,
   output logic [1:0]  o_idx,
   output logic [31:0] o_word
);

   logic [1:0]  r_idx;
   logic [31:0] r_word;

   // Clear on an accepted read, otherwise drop each popped byte into lane r_idx.
   always_ff @(posedge i_clk) begin
      if (!i_n_rst) begin
         r_idx  <= 2'd0;
         r_word <= 32'd0;
      end else if (i_clear) begin
         r_idx  <= 2'd0;
         r_word <= 32'd0;
      end else if (i_capture) begin
         r_word[{r_idx, 3'b000} +: 8] <= i_byte;
         r_idx                        <= r_idx + 2'd1;
      end
   end

   assign o_idx  = r_idx;
   assign o_word = r_word;

endmodule

// File: rtl/rx_buffer_ctrl.sv
// Arbitrates the RX data buffer between USB RX stores, AHB reads and flushes.
// Optional overflow guard: define RX_BUF_CTRL_OVF_GUARD_EN to block stores at
// occupancy BUF_DEPTH-1 and expose the sticky o_ovf flag.
module rx_buffer_ctrl
   import rx_buf_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_n_rst,
   input  logic        i_rx_store_req,
   input  logic [7:0]  i_rx_byte,
   input  logic        i_ahb_rd_req,
   input  logic [1:0]  i_ahb_rd_size,
   input  logic        i_ahb_flush_req,
   input  logic [6:0]  i_buffer_occupancy,
   input  logic [7:0]  i_buf_rx_data,
   output logic        o_store_rx_packet_data,
   output logic [7:0]  o_rx_packet_data,
   output logic        o_get_rx_data,
   output logic        o_flush,
   output logic [31:0] o_rd_data,
   output logic        o_rd_done,
   output logic        o_rd_err,
   output logic        o_busy
`ifdef RX_BUF_CTRL_OVF_GUARD_EN
   ,
   output logic        o_ovf
`endif
);

   rx_state_e r_state;
   logic [2:0] r_cnt;
   logic       r_flush_pend;
   logic       r_rd_done;
   logic       r_rd_err;
   logic       r_flush;

   logic [2:0] w_req_bytes;
   logic       w_req_ok;
   logic       w_flush_any;
   logic       w_capture;
   logic       w_clear;
   logic       w_last;
   logic [1:0] w_idx;
   logic       w_store_ok;

   assign w_req_bytes = size_to_bytes(i_ahb_rd_size);
   assign w_req_ok    = (w_req_bytes != 3'd0) && (i_buffer_occupancy >= {4'd0, w_req_bytes});
   assign w_flush_any = i_ahb_flush_req | r_flush_pend;
   // A store owns the buffer port for the cycle, so the pop stalls.
   assign w_capture   = (r_state == StRead) && !i_rx_store_req;
   assign w_clear     = (r_state == StIdle) && !w_flush_any && i_ahb_rd_req && w_req_ok;
   assign w_last      = w_capture && ({1'b0, w_idx} == (r_cnt - 3'd1));

   // Control FSM with registered completion, error and flush pulses.
   always_ff @(posedge i_clk) begin
      if (!i_n_rst) begin
         r_state      <= StIdle;
         r_cnt        <= 3'd0;
         r_flush_pend <= 1'b0;
         r_rd_done    <= 1'b0;
         r_rd_err     <= 1'b0;
         r_flush      <= 1'b0;
      end else begin
         r_rd_done <= 1'b0;
         r_rd_err  <= 1'b0;
         r_flush   <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_flush_any) begin
                  r_state <= StFlush;
                  r_flush <= 1'b1;
               end else if (i_ahb_rd_req) begin
                  if (w_req_ok) begin
                     r_state <= StRead;
                     r_cnt   <= w_req_bytes;
                  end else begin
                     r_rd_err <= 1'b1;
                  end
               end
            end
            StRead: begin
               if (i_ahb_flush_req) r_flush_pend <= 1'b1;
               if (w_last) begin
                  r_state   <= StDone;
                  r_rd_done <= 1'b1;
               end
            end
            StDone: begin
               if (i_ahb_flush_req) r_flush_pend <= 1'b1;
               r_state <= StIdle;
            end
            StFlush: begin
               // The flush in progress covers any request that arrives now.
               r_flush_pend <= 1'b0;
               r_state      <= StIdle;
            end
         endcase
      end
   end

   rx_word_assembler u_asm (
      .i_clk     (i_clk),
      .i_n_rst   (i_n_rst),
      .i_clear   (w_clear),
      .i_capture (w_capture),
      .i_byte    (i_buf_rx_data),
      .o_idx     (w_idx),
      .o_word    (o_rd_data)
   );

   assign w_store_ok = i_rx_store_req && (r_state != StFlush);

`ifdef RX_BUF_CTRL_OVF_GUARD_EN
   localparam logic [6:0] OvfLevel = 7'(BUF_DEPTH - 1);

   logic w_ovf_hit;
   logic r_ovf;

   assign w_ovf_hit = w_store_ok && (i_buffer_occupancy == OvfLevel);

   // Sticky overflow flag, cleared only by a flush or reset.
   always_ff @(posedge i_clk) begin
      if (!i_n_rst) begin
         r_ovf <= 1'b0;
      end else if (r_state == StFlush) begin
         r_ovf <= 1'b0;
      end else if (w_ovf_hit) begin
         r_ovf <= 1'b1;
      end
   end

   assign o_ovf                  = r_ovf;
   assign o_store_rx_packet_data = w_store_ok && !w_ovf_hit;
`else
   assign o_store_rx_packet_data = w_store_ok;
`endif

   assign o_rx_packet_data = (r_state == StFlush) ? 8'd0 : i_rx_byte;
   assign o_get_rx_data    = w_capture;
   assign o_flush          = r_flush;
   assign o_rd_done        = r_rd_done;
   assign o_rd_err         = r_rd_err;
   assign o_busy           = (r_state != StIdle);

endmodule

// File: tb/tb_rx_buffer_ctrl.sv
// Bench for rx_buffer_ctrl: directed vector table, hand sequences, then random
// traffic against a transaction-level reference model.
module tb_rx_buffer_ctrl;

   logic        clk;
   logic        n_rst;
   logic        rx_store_req;
   logic [7:0]  rx_byte;
   logic        ahb_rd_req;
   logic [1:0]  ahb_rd_size;
   logic        ahb_flush_req;
   logic [6:0]  buffer_occupancy;
   logic [7:0]  buf_rx_data;
   logic        store_rx_packet_data;
   logic [7:0]  rx_packet_data;
   logic        get_rx_data;
   logic        flush;
   logic [31:0] rd_data;
   logic        rd_done;
   logic        rd_err;
   logic        busy;
`ifdef RX_BUF_CTRL_OVF_GUARD_EN
   logic        ovf;
`endif

   int errors = 0;
   int checks = 0;

   rx_buffer_ctrl dut (
      .i_clk                  (clk),
      .i_n_rst                (n_rst),
      .i_rx_store_req         (rx_store_req),
      .i_rx_byte              (rx_byte),
      .i_ahb_rd_req           (ahb_rd_req),
      .i_ahb_rd_size          (ahb_rd_size),
      .i_ahb_flush_req        (ahb_flush_req),
      .i_buffer_occupancy     (buffer_occupancy),
      .i_buf_rx_data          (buf_rx_data),
      .o_store_rx_packet_data (store_rx_packet_data),
      .o_rx_packet_data       (rx_packet_data),
      .o_get_rx_data          (get_rx_data),
      .o_flush                (flush),
      .o_rd_data              (rd_data),
      .o_rd_done              (rd_done),
      .o_rd_err               (rd_err),
      .o_busy                 (busy)
`ifdef RX_BUF_CTRL_OVF_GUARD_EN
      ,
      .o_ovf                  (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic st, input logic [7:0] b, input logic rq,
                        input logic [1:0] sz, input logic fq, input logic [6:0] occ,
                        input logic [7:0] bd);
      rx_store_req     = st;
      rx_byte          = b;
      ahb_rd_req       = rq;
      ahb_rd_size      = sz;
      ahb_flush_req    = fq;
      buffer_occupancy = occ;
      buf_rx_data      = bd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Directed vector: inputs for one cycle and the outputs expected in that cycle.
   typedef struct {
      logic        st;
      logic [7:0]  b;
      logic        rq;
      logic [1:0]  sz;
      logic        fq;
      logic [6:0]  occ;
      logic [7:0]  bd;
      logic        e_get;
      logic        e_sto;
      logic        e_done;
      logic        e_err;
      logic        e_fl;
      logic        e_busy;
      logic        ck_data;
      logic [31:0] e_data;
   } vec_t;

   function automatic vec_t mk(input logic st, input logic [7:0] b, input logic rq,
                               input logic [1:0] sz, input logic fq, input logic [6:0] occ,
                               input logic [7:0] bd, input logic e_get, input logic e_sto,
                               input logic e_done, input logic e_err, input logic e_fl,
                               input logic e_busy, input logic ck, input logic [31:0] e_data);
      vec_t v;
      v.st = st; v.b = b; v.rq = rq; v.sz = sz; v.fq = fq; v.occ = occ; v.bd = bd;
      v.e_get = e_get; v.e_sto = e_sto; v.e_done = e_done; v.e_err = e_err;
      v.e_fl = e_fl; v.e_busy = e_busy; v.ck_data = ck; v.e_data = e_data;
      return v;
   endfunction

   // Reference model: a read is "N bytes still owed"; flush and done are one-cycle events.
   bit          m_reading;
   int          m_need;
   int          m_got;
   logic [31:0] m_word;
   bit          m_done;
   bit          m_err;
   bit          m_flush;
   bit          m_pend;
   bit          m_ovf;

   function automatic void model_reset();
      m_reading = 0; m_need = 0; m_got = 0; m_word = '0;
      m_done = 0; m_err = 0; m_flush = 0; m_pend = 0; m_ovf = 0;
   endfunction

   function automatic bit model_store_blocked();
`ifdef RX_BUF_CTRL_OVF_GUARD_EN
      return buffer_occupancy == 7'd63;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_check(input int cyc);
      bit exp_sto;
      exp_sto = rx_store_req && !m_flush && !model_store_blocked();
      chk($sformatf("rnd%0d.get", cyc), get_rx_data, m_reading && !rx_store_req);
      chk($sformatf("rnd%0d.store", cyc), store_rx_packet_data, exp_sto);
      chk($sformatf("rnd%0d.byte", cyc), rx_packet_data, m_flush ? 8'd0 : rx_byte);
      chk($sformatf("rnd%0d.done", cyc), rd_done, m_done);
      chk($sformatf("rnd%0d.err", cyc), rd_err, m_err);
      chk($sformatf("rnd%0d.flush", cyc), flush, m_flush);
      chk($sformatf("rnd%0d.busy", cyc), busy, m_reading || m_done || m_flush);
      chk($sformatf("rnd%0d.data", cyc), rd_data, m_word);
      chk($sformatf("rnd%0d.excl", cyc), get_rx_data & store_rx_packet_data, 1'b0);
`ifdef RX_BUF_CTRL_OVF_GUARD_EN
      chk($sformatf("rnd%0d.ovf", cyc), ovf, m_ovf);
`endif
   endtask

   function automatic void model_update();
      int n;
      bit was_flush;
      if (!n_rst) begin
         model_reset();
         return;
      end
      was_flush = m_flush;
`ifdef RX_BUF_CTRL_OVF_GUARD_EN
      if (was_flush) m_ovf = 0;
      else if (rx_store_req && buffer_occupancy == 7'd63) m_ovf = 1;
`endif
      m_err = 0;
      m_flush = 0;
      if (was_flush) begin
         m_pend = 0;
      end else if (m_done) begin
         m_done = 0;
         if (ahb_flush_req) m_pend = 1;
      end else if (m_reading) begin
         if (ahb_flush_req) m_pend = 1;
         if (!rx_store_req) begin
            m_word = m_word | ({24'd0, buf_rx_data} << (8 * m_got));
            m_got++;
            if (m_got == m_need) begin
               m_reading = 0;
               m_done = 1;
            end
         end
      end else if (ahb_flush_req || m_pend) begin
         m_flush = 1;
      end else if (ahb_rd_req) begin
         n = (ahb_rd_size == 2'd0) ? 1 : (ahb_rd_size == 2'd1) ? 2 :
             (ahb_rd_size == 2'd2) ? 4 : 0;
         if (n != 0 && int'(buffer_occupancy) >= n) begin
            m_reading = 1; m_need = n; m_got = 0; m_word = '0;
         end else begin
            m_err = 1;
         end
      end
   endfunction

   vec_t vecs[$];

   initial begin
      // Columns: st, byte, rq, size, fq, occ, bufdata | get, sto, done, err, flush, busy | ck, data
      // Word read of 4 bytes
      vecs.push_back(mk(0, 8'h00, 1, 2, 0, 8, 8'h00, 0, 0, 0, 0, 0, 0, 1, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8, 8'h11, 1, 0, 0, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8, 8'h22, 1, 0, 0, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8, 8'h33, 1, 0, 0, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8, 8'h44, 1, 0, 0, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8, 8'h00, 0, 0, 1, 0, 0, 1, 1, 32'h44332211));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8, 8'h00, 0, 0, 0, 0, 0, 0, 1, 32'h44332211));
      // Half read with only one byte buffered -> error, data held
      vecs.push_back(mk(0, 8'h00, 1, 1, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 0, 1, 0, 0, 1, 32'h44332211));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 32'h0));
      // Reserved size -> error even with a full buffer
      vecs.push_back(mk(0, 8'h00, 1, 3, 0, 64, 8'h00, 0, 0, 0, 0, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 64, 8'h00, 0, 0, 0, 1, 0, 0, 1, 32'h44332211));
      // Half read at exactly two buffered bytes
      vecs.push_back(mk(0, 8'h00, 1, 1, 0, 2, 8'h00, 0, 0, 0, 0, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 2, 8'h01, 1, 0, 0, 0, 0, 1, 1, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 2, 8'h02, 1, 0, 0, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 2, 8'h00, 0, 0, 1, 0, 0, 1, 1, 32'h00000201));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 2, 8'h00, 0, 0, 0, 0, 0, 0, 0, 32'h0));
      // Word read with a store stealing cycle 2
      vecs.push_back(mk(0, 8'h00, 1, 2, 0, 8, 8'h00, 0, 0, 0, 0, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8, 8'hA1, 1, 0, 0, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk(1, 8'h5A, 0, 0, 0, 8, 8'hEE, 0, 1, 0, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8, 8'hA2, 1, 0, 0, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8, 8'hA3, 1, 0, 0, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8, 8'hA4, 1, 0, 0, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8, 8'h00, 0, 0, 1, 0, 0, 1, 1, 32'hA4A3A2A1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8, 8'h00, 0, 0, 0, 0, 0, 0, 0, 32'h0));
      // Flush and read together: flush wins, store dropped during flush
      vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8, 8'h00, 0, 0, 0, 0, 0, 0, 0, 32'h0));
      vecs.push_back(mk(1, 8'h66, 0, 0, 0, 8, 8'h00, 0, 0, 0, 0, 1, 1, 1, 32'hA4A3A2A1));
      vecs.push_back(mk(1, 8'h3C, 0, 0, 0, 8, 8'h00, 0, 1, 0, 0, 0, 0, 1, 32'hA4A3A2A1));
      // Flush request during a read is held until the FSM is idle again
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8, 8'h00, 0, 0, 0, 0, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8, 8'h77, 1, 0, 0, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8, 8'h00, 0, 0, 1, 0, 0, 1, 1, 32'h00000077));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8, 8'h00, 0, 0, 0, 0, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8, 8'h00, 0, 0, 0, 0, 1, 1, 0, 32'h0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8, 8'h00, 0, 0, 0, 0, 0, 0, 0, 32'h0));

      // Reset state
      drive(0, 8'h00, 0, 0, 0, 0, 8'h00);
      n_rst = 1'b0;
      step();
      step();
      n_rst = 1'b1;
      @(negedge clk);
      chk("rst.busy", busy, 1'b0);
      chk("rst.get", get_rx_data, 1'b0);
      chk("rst.done", rd_done, 1'b0);
      chk("rst.err", rd_err, 1'b0);
      chk("rst.flush", flush, 1'b0);
      chk("rst.data", rd_data, 32'h0);
`ifdef RX_BUF_CTRL_OVF_GUARD_EN
      chk("rst.ovf", ovf, 1'b0);
`endif
      step();

      foreach (vecs[i]) begin
         drive(vecs[i].st, vecs[i].b, vecs[i].rq, vecs[i].sz, vecs[i].fq, vecs[i].occ,
               vecs[i].bd);
         @(negedge clk);
         chk($sformatf("v%0d.get", i), get_rx_data, vecs[i].e_get);
         chk($sformatf("v%0d.store", i), store_rx_packet_data, vecs[i].e_sto);
         chk($sformatf("v%0d.done", i), rd_done, vecs[i].e_done);
         chk($sformatf("v%0d.err", i), rd_err, vecs[i].e_err);
         chk($sformatf("v%0d.flush", i), flush, vecs[i].e_fl);
         chk($sformatf("v%0d.busy", i), busy, vecs[i].e_busy);
         if (vecs[i].e_sto) chk($sformatf("v%0d.byte", i), rx_packet_data, vecs[i].b);
         if (vecs[i].ck_data) chk($sformatf("v%0d.data", i), rd_data, vecs[i].e_data);
         step();
      end

      // Reset in the middle of a word read discards the partial word
      drive(0, 8'h00, 1, 2, 0, 8, 8'h00);
      step();
      drive(0, 8'h00, 0, 0, 0, 8, 8'h11);
      step();
      drive(0, 8'h00, 0, 0, 0, 8, 8'h22);
      step();
      drive(0, 8'h00, 0, 0, 0, 8, 8'h33);
      @(negedge clk);
      chk("mid.partial", rd_data, 32'h00002211);
      n_rst = 1'b0;
      step();
      n_rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("mid%0d.busy", k), busy, 1'b0);
         chk($sformatf("mid%0d.done", k), rd_done, 1'b0);
         chk($sformatf("mid%0d.get", k), get_rx_data, 1'b0);
         chk($sformatf("mid%0d.data", k), rd_data, 32'h0);
         step();
      end

`ifdef RX_BUF_CTRL_OVF_GUARD_EN
      // Store at occupancy 63 is blocked and latches ovf until a flush
      drive(1, 8'h99, 0, 0, 0, 63, 8'h00);
      @(negedge clk);
      chk("ovf.block", store_rx_packet_data, 1'b0);
      chk("ovf.pre", ovf, 1'b0);
      step();
      drive(0, 8'h00, 0, 0, 0, 10, 8'h00);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("ovf.sticky%0d", k), ovf, 1'b1);
         step();
      end
      drive(0, 8'h00, 0, 0, 1, 10, 8'h00);
      step();
      drive(0, 8'h00, 0, 0, 0, 10, 8'h00);
      @(negedge clk);
      chk("ovf.flush", flush, 1'b1);
      chk("ovf.inflush", ovf, 1'b1);
      step();
      drive(1, 8'h42, 0, 0, 0, 62, 8'h00);
      @(negedge clk);
      chk("ovf.cleared", ovf, 1'b0);
      chk("ovf.pass62", store_rx_packet_data, 1'b1);
      step();
`endif

      // Random traffic against the reference model
      drive(0, 8'h00, 0, 0, 0, 0, 8'h00);
      n_rst = 1'b0;
      step();
      n_rst = 1'b1;
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         n_rst = ($urandom_range(0, 99) != 0);
         rx_store_req = ($urandom_range(0, 9) < 3);
         rx_byte = 8'($urandom);
         ahb_rd_req = ($urandom_range(0, 9) < 3);
         ahb_rd_size = 2'($urandom_range(0, 3));
         ahb_flush_req = ($urandom_range(0, 19) == 0);
         buffer_occupancy = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 6))
                                                         : 7'($urandom_range(0, 64));
         if ($urandom_range(0, 9) == 0) buffer_occupancy = 7'd63;
         buf_rx_data = 8'($urandom);
         @(negedge clk);
         model_check(c);
         model_update();
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
